// File: rtl/elevator_dispatch_scheduler.sv
// Hall-call dispatcher: latches calls into a pending mask, scans call slots at the
// simulation pace, and hands each call to the nearest idle, unreserved car.
module elevator_dispatch_scheduler #(
  parameter int FLOORS    = 6,
  parameter int ELEVATORS = 4,
  parameter int FW        = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              sim_state,
  input  logic [2:0]              sim_speed,
  input  logic [2*FLOORS-1:0]     floors_requested,
  input  logic [2*ELEVATORS-1:0]  elevator_states,
  input  logic [FW*ELEVATORS-1:0] car_floor,
  input  logic [ELEVATORS-1:0]    assign_ack,
  output logic [ELEVATORS-1:0]    assign_valid,
  output logic [FW-1:0]           assign_floor,
  output logic                    assign_dir,
  output logic [2*FLOORS-1:0]     pending,
  output logic                    busy
);

  localparam int SLOTS = 2 * FLOORS;
  localparam int PW    = $clog2(SLOTS);
  localparam int EW    = (ELEVATORS > 1) ? $clog2(ELEVATORS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_EVAL  = 2'd2;
  localparam logic [1:0] ST_ISSUE = 2'd3;

  logic [1:0]           state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        slot;
  logic [EW-1:0]        sel;
  logic [ELEVATORS-1:0] reserved;
  logic [2:0]           tick;

  logic                 run;
  logic                 stop;
  logic                 step;
  logic                 ack_ok;
  logic [ELEVATORS-1:0] nonidle;
  logic [SLOTS-1:0]     clr_mask;
  logic [ELEVATORS-1:0] set_mask;
  logic                 best_found;
  logic [EW-1:0]        best_idx;
  logic [FW-1:0]        best_dist;
  logic [FW-1:0]        tgt_floor;
  logic [FW-1:0]        cur_floor;
  logic [FW-1:0]        cur_dist;

  // Slots [FLOORS-1:0] are up calls, the upper half down calls at the same floors.
  function automatic logic [FW-1:0] slot_floor(input logic [PW-1:0] k);
    logic [PW-1:0] f;
    f = (k >= PW'(FLOORS)) ? k - PW'(FLOORS) : k;
    return f[FW-1:0];
  endfunction

  function automatic logic slot_dir(input logic [PW-1:0] k);
    return (k >= PW'(FLOORS));
  endfunction

  function automatic logic [PW-1:0] next_slot(input logic [PW-1:0] k);
    return (k == PW'(SLOTS - 1)) ? '0 : k + 1'b1;
  endfunction

  function automatic logic [FW-1:0] abs_diff(input logic [FW-1:0] a, input logic [FW-1:0] b);
    logic signed [FW:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return (diff < 0) ? FW'(-diff) : FW'(diff);
  endfunction

  assign run    = (sim_state == 2'b01);
  assign stop   = (sim_state == 2'b00);
  assign step   = run && (sim_speed != 3'd0) && (tick == (3'd7 - sim_speed));
  assign ack_ok = run && (state == ST_ISSUE) && assign_ack[sel];
  assign busy   = (state != ST_IDLE);

  assign clr_mask = ack_ok ? ({{(SLOTS-1){1'b0}}, 1'b1} << slot) : '0;
  assign set_mask = ack_ok ? ({{(ELEVATORS-1){1'b0}}, 1'b1} << sel) : '0;

  always_comb begin
    for (int i = 0; i < ELEVATORS; i++) begin
      nonidle[i] = (elevator_states[2*i +: 2] != 2'b00);
    end
  end

  // Nearest eligible car; strict '<' keeps the lowest index on a tie.
  always_comb begin
    best_found = 1'b0;
    best_idx   = '0;
    best_dist  = '1;
    cur_floor  = '0;
    cur_dist   = '0;
    tgt_floor  = slot_floor(slot);
    for (int i = 0; i < ELEVATORS; i++) begin
      cur_floor = car_floor[i*FW +: FW];
      cur_dist  = abs_diff(cur_floor, tgt_floor);
      if (!nonidle[i] && !reserved[i] && ({1'b0, cur_floor} < (FW+1)'(FLOORS))) begin
        if (!best_found || (cur_dist < best_dist)) begin
          best_found = 1'b1;
          best_idx   = EW'(i);
          best_dist  = cur_dist;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= '0;
    end else if (run && (sim_speed != 3'd0)) begin
      tick <= step ? 3'd0 : tick + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      slot         <= '0;
      sel          <= '0;
      reserved     <= '0;
      pending      <= '0;
      assign_valid <= '0;
      assign_floor <= '0;
      assign_dir   <= 1'b0;
    end else if (stop) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      reserved     <= '0;
      pending      <= '0;
      assign_valid <= '0;
    end else begin
      // A fresh request on the bit being cleared survives the clear.
      pending  <= (pending & ~clr_mask) | floors_requested;
      reserved <= (reserved & ~nonidle) | set_mask;
      if (run) begin
        case (state)
          ST_IDLE: state <= ST_SCAN;
          ST_SCAN: begin
            if (step) begin
              if (pending[ptr]) begin
                slot  <= ptr;
                state <= ST_EVAL;
              end else begin
                ptr <= next_slot(ptr);
              end
            end
          end
          ST_EVAL: begin
            if (best_found) begin
              sel          <= best_idx;
              assign_valid <= {{(ELEVATORS-1){1'b0}}, 1'b1} << best_idx;
              assign_floor <= slot_floor(slot);
              assign_dir   <= slot_dir(slot);
              state        <= ST_ISSUE;
            end else begin
              ptr   <= next_slot(slot);
              state <= ST_SCAN;
            end
          end
          default: begin
            if (ack_ok) begin
              assign_valid <= '0;
              ptr          <= next_slot(slot);
              state        <= ST_SCAN;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elevator_dispatch_scheduler.sv
// Directed bench for elevator_dispatch_scheduler with a cycle-level behavioural model
// compared on every clock plus hand-computed literal checks.
module tb_elevator_dispatch_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sim_state;
  logic [2:0]  sim_speed;
  logic [11:0] floors_requested;
  logic [7:0]  elevator_states;
  logic [11:0] car_floor;
  logic [3:0]  assign_ack;
  logic [3:0]  assign_valid;
  logic [2:0]  assign_floor;
  logic        assign_dir;
  logic [11:0] pending;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  elevator_dispatch_scheduler dut (
    .clk(clk), .rst(rst), .sim_state(sim_state), .sim_speed(sim_speed),
    .floors_requested(floors_requested), .elevator_states(elevator_states),
    .car_floor(car_floor), .assign_ack(assign_ack), .assign_valid(assign_valid),
    .assign_floor(assign_floor), .assign_dir(assign_dir), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: phases of the dispatcher, integer slot/car arithmetic.
  localparam int PH_IDLE = 0, PH_SCAN = 1, PH_EVAL = 2, PH_ISSUE = 3;
  int          m_phase, m_ptr, m_slot, m_sel, m_tick;
  logic [11:0] m_pend;
  logic [3:0]  m_res, m_valid;
  int          m_floor, m_dir;

  task automatic model_reset();
    m_phase = PH_IDLE; m_ptr = 0; m_slot = 0; m_sel = 0; m_tick = 0;
    m_pend = '0; m_res = '0; m_valid = '0; m_floor = 0; m_dir = 0;
  endtask

  task automatic model_step();
    bit run, stop, stp, ack_ok;
    int best, bd, d, cf, tf;
    logic [11:0] np;
    logic [3:0]  nr;
    run    = (sim_state == 2'b01);
    stop   = (sim_state == 2'b00);
    stp    = run && (sim_speed != 0) && (m_tick == 7 - int'(sim_speed));
    ack_ok = run && (m_phase == PH_ISSUE) && assign_ack[m_sel];
    if (run && sim_speed != 0) m_tick = stp ? 0 : (m_tick + 1) % 8;
    if (stop) begin
      m_phase = PH_IDLE; m_ptr = 0; m_res = '0; m_pend = '0; m_valid = '0;
      return;
    end
    np = m_pend;
    if (ack_ok) np[m_slot] = 1'b0;
    np = np | floors_requested;
    nr = m_res;
    for (int i = 0; i < 4; i++) if (elevator_states[2*i +: 2] != 2'b00) nr[i] = 1'b0;
    if (ack_ok) nr[m_sel] = 1'b1;
    if (run) begin
      case (m_phase)
        PH_IDLE: m_phase = PH_SCAN;
        PH_SCAN: if (stp) begin
          if (m_pend[m_ptr]) begin m_slot = m_ptr; m_phase = PH_EVAL; end
          else m_ptr = (m_ptr + 1) % 12;
        end
        PH_EVAL: begin
          best = -1; bd = 1000; tf = m_slot % 6;
          for (int i = 0; i < 4; i++) begin
            cf = int'(car_floor[3*i +: 3]);
            d  = (cf > tf) ? cf - tf : tf - cf;
            if (elevator_states[2*i +: 2] == 2'b00 && !m_res[i] && cf < 6 && d < bd) begin
              best = i; bd = d;
            end
          end
          if (best < 0) begin m_ptr = (m_slot + 1) % 12; m_phase = PH_SCAN; end
          else begin
            m_sel = best; m_valid = 4'b0001 << best;
            m_floor = tf; m_dir = (m_slot >= 6) ? 1 : 0; m_phase = PH_ISSUE;
          end
        end
        default: if (ack_ok) begin
          m_valid = '0; m_ptr = (m_slot + 1) % 12; m_phase = PH_SCAN;
        end
      endcase
    end
    m_pend = np; m_res = nr;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if (assign_valid !== m_valid || pending !== m_pend || busy !== (m_phase != PH_IDLE) ||
          (m_valid != 0 && (int'(assign_floor) != m_floor || int'(assign_dir) != m_dir))) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t (got/exp) valid=%b/%b floor=%0d/%0d dir=%0d/%0d pending=%h/%h busy=%0d/%0d",
                 $time, assign_valid, m_valid, assign_floor, m_floor, assign_dir, m_dir,
                 pending, m_pend, busy, (m_phase != PH_IDLE));
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_req(input logic [11:0] bits);
    floors_requested = bits; cyc(1); floors_requested = '0;
  endtask

  task automatic wait_valid(input string name);
    int cnt = 0;
    while (assign_valid == 4'b0000 && cnt < 60) begin cyc(1); cnt++; end
    if (assign_valid == 4'b0000) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout waiting for assign_valid", name);
    end
  endtask

  task automatic ack_current();
    assign_ack = assign_valid; cyc(1); assign_ack = '0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1; cyc(2); rst = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; sim_state = 2'b00; sim_speed = 3'd7; floors_requested = '0;
    elevator_states = 8'h00; car_floor = {3'd2, 3'd2, 3'd5, 3'd0}; assign_ack = '0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("reset_valid", assign_valid, 0);
    chk("reset_pending", pending, 0);
    chk("reset_busy", busy, 0);

    // Nearest car with tie to lowest index; stray acks ignored.
    sim_state = 2'b01;
    cyc(2);
    pulse_req(12'h008);
    wait_valid("up3");
    chk("up3_valid", assign_valid, 4'b0100);
    chk("up3_floor", assign_floor, 3);
    chk("up3_dir", assign_dir, 0);
    assign_ack = 4'b1011; cyc(2); assign_ack = '0;
    chk("stray_ack_valid", assign_valid, 4'b0100);
    chk("stray_ack_pending", pending, 12'h008);
    ack_current();
    chk("up3_ack_valid", assign_valid, 0);
    chk("up3_ack_pending", pending, 12'h000);

    // Reserved car 2 is skipped; new request on the cleared bit wins.
    pulse_req(12'h200);
    wait_valid("dn3");
    chk("dn3_valid", assign_valid, 4'b1000);
    chk("dn3_floor", assign_floor, 3);
    chk("dn3_dir", assign_dir, 1);
    assign_ack = 4'b1000; floors_requested = 12'h200; cyc(1);
    assign_ack = '0; floors_requested = '0;
    chk("set_wins_pending", pending, 12'h200);
    wait_valid("dn3_again");
    chk("dn3_again_valid", assign_valid, 4'b0010);
    ack_current();

    // No idle car: scan keeps rotating, call stays pending until car 1 frees up.
    elevator_states = 8'b0101_0101;
    cyc(1);
    pulse_req(12'h001);
    cyc(30);
    chk("allup_valid", assign_valid, 0);
    chk("allup_pending", pending, 12'h001);
    chk("allup_busy", busy, 1);
    elevator_states = 8'b0101_0001;
    wait_valid("car1_free");
    chk("car1_valid", assign_valid, 4'b0010);
    chk("car1_floor", assign_floor, 0);
    ack_current();
    elevator_states = 8'h00;
    cyc(2);

    // Speed 4: steps every 4 cycles, slot 2 examined on the third step.
    rst = 1'b1; sim_state = 2'b01; sim_speed = 3'd4; cyc(2);
    rst = 1'b0; floors_requested = 12'h004;
    cyc(1); floors_requested = '0;
    cnt = 1;
    while (assign_valid == 4'b0000 && cnt < 40) begin cyc(1); cnt++; end
    chk("speed4_latency", cnt, 13);
    chk("speed4_valid", assign_valid, 4'b0100);
    ack_current();

    // Speed 0: scanning never advances.
    rst = 1'b1; sim_speed = 3'd0; cyc(2);
    rst = 1'b0;
    pulse_req(12'h001);
    cyc(30);
    chk("speed0_valid", assign_valid, 0);
    chk("speed0_busy", busy, 1);
    chk("speed0_pending", pending, 12'h001);

    // Pause holds an in-flight assignment; stop drops everything and ignores the ack.
    sim_speed = 3'd7;
    wait_valid("pause_issue");
    chk("pause_pre_valid", assign_valid, 4'b0001);
    sim_state = 2'b10; cyc(5);
    sim_state = 2'b11; cyc(5);
    chk("pause_valid", assign_valid, 4'b0001);
    chk("pause_busy", busy, 1);
    sim_state = 2'b00; assign_ack = 4'b0001; cyc(1); assign_ack = '0;
    chk("stop_valid", assign_valid, 0);
    chk("stop_pending", pending, 0);
    chk("stop_busy", busy, 0);

    // Asynchronous reset mid-issue.
    sim_state = 2'b01;
    cyc(2);
    pulse_req(12'h002);
    wait_valid("rst_issue");
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", assign_valid, 0);
    chk("async_rst_pending", pending, 0);
    chk("async_rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_dispatch_scheduler.md
Name: elevator_dispatch_scheduler

Overview:
- Arbitrates hall calls from the people controller among the elevator cars.
- Latches call requests into a pending mask and round-robin scans the call slots, paced by the simulation speed.
- For each pending call, picks the nearest idle, unreserved car and issues a one-hot assignment with a valid/ack handshake.
- Sits between the people controller (floorsRequested, sim_state, sim_speed) and the per-car motion controllers.

Parameters:
- FLOORS, 6, number of floors; calls are 2*FLOORS bits.
- ELEVATORS, 4, number of cars.
- FW, 3, floor index width.
- Only the defaults are verified.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sim_state  in  2  00 STOP, 01 RUN, 10 PAUSE, 11 treated as PAUSE
- sim_speed  in  3  step pacing; 0 = halted
- floors_requested  in  12  hall calls; bits [5:0] = up call at floor f, bits [11:6] = down call at floor f
- elevator_states  in  8  2 bits per car (car i at [2i+1:2i]): 00 IDLE, 01 UP, 10 DOWN, 11 DOORS
- car_floor  in  12  3 bits per car, current floor
- assign_ack  in  4  per-car acceptance strobe
- assign_valid  out  4  one-hot assignment request
- assign_floor  out  3  target floor of the current assignment
- assign_dir  out  1  0 = up call, 1 = down call
- pending  out  12  latched unserved calls
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=1): all outputs 0, pending=0, scan pointer=0, reserved mask=0, tick counter=0, FSM=IDLE.
- Pending latch:
  - Every cycle, pending |= floors_requested, except when sim_state=STOP, which clears pending to 0.
  - Pending bit k is cleared in the cycle assign_ack is sampled for slot k.
  - A new request on the same bit in the same cycle as its clear keeps the bit set (set wins).
- Tick:
  - 3-bit counter runs only when sim_state=RUN and sim_speed≠0.
  - step pulses when the counter reaches (7 - sim_speed), then the counter reloads to 0. Step interval = 8 - sim_speed cycles; speed 7 gives a step every cycle.
- FSM:
  - IDLE: go to SCAN when sim_state=RUN.
  - SCAN: on step, examine slot ptr.
    - If pending[ptr]=0: ptr advances modulo 12.
    - Else: latch slot, go to EVAL.
  - EVAL, one cycle:
    - Eligible car = state IDLE and not reserved.
    - Distance = |car_floor - slot floor|; choose the minimum; ties go to the lowest index.
    - No eligible car: ptr advances, back to SCAN, pending kept.
    - Otherwise go to ISSUE.
  - ISSUE: drive assign_valid one-hot plus assign_floor/assign_dir, registered, visible the cycle after EVAL. Hold stable until ack.
  - Ack acceptance: assign_ack[i] for the selected car only. Then:
    - clear the pending bit;
    - set reserved[i];
    - deassign next cycle;
    - ptr = slot+1 mod 12;
    - return to SCAN.
  - Acks on non-selected cars are ignored.
- Reservation: reserved[i] clears on the first cycle the car i state ≠ IDLE. This prevents double-dispatch before the car starts moving.
- sim_state PAUSE: FSM freezes in its current state, tick halts, and an in-flight assign_valid is held.
- sim_state STOP from any state:
  - next cycle FSM=IDLE, assign_valid=0, pending=0, reserved=0, ptr=0;
  - an ack in that same cycle is ignored.
- Bounds: car_floor ≥ FLOORS makes that car ineligible. Slot floor = k mod 6.
- busy=1 whenever FSM≠IDLE.

Test Plan:
- Reset mid-ISSUE (rst pulsed asynchronously between clock edges) -> assign_valid, pending, busy read 0 immediately, before the next edge.
- RUN, speed=7, all cars IDLE at floors {0,5,2,2}, floors_requested pulses bit 3 (up, floor 3) -> assign_valid=4'b0100, assign_floor=3, assign_dir=0. Ack car 2 -> pending=0, reserved car 2.
- Same setup, second call bit 9 (down, floor 3) while car 2 is still IDLE and reserved -> car 3 chosen (distance 1, tie broken to lower index among eligible), assign_valid=4'b1000.
- All cars UP (elevator_states=8'b0101_0101), pending bit 0 -> scan rotates without issuing, pending stays 12'h001. Car 1 goes IDLE -> assign_valid=4'b0010.
- sim_speed=4 -> step every 4 cycles; ptr advances 0→1→2 at cycles 4, 8. sim_speed=0 -> ptr never moves.
- During ISSUE, sim_state→PAUSE for 10 cycles -> assign_valid held. Then sim_state→STOP -> assign_valid=0, pending=0, FSM IDLE next cycle.
